// File: rtl/player_motion.sv
// Per-frame player physics and state controller.
// Owns the player position registers that feed the combinational collision checker and
// consumes its flags to walk, jump, fall, land, die and win. All motion happens on frame_tick.
// Ports:
//   clk, reset (sync, active-high), frame_tick (1-cycle pulse per frame)
//   btn_left/right/jump/restart   synchronised button levels
//   on_ground, support_y, hit_ceiling, hit_left_wall, hit_right_wall, at_goal_region, in_lava
//                                 collision flags for the current player_x/player_y
//   player_x, player_y            registered top-left of the 16x16 player
//   motion_state                  00 GROUND, 01 AIR, 10 DEAD, 11 WON
//   facing_left, player_dead, level_complete
module player_motion #(
  parameter logic [9:0] SPAWN_X    = 10'd10,
  parameter logic [9:0] SPAWN_Y    = 10'd344,
  parameter logic [9:0] WALK_SPEED = 10'd2,
  parameter logic [5:0] JUMP_V     = 6'd8,
  parameter logic [5:0] GRAVITY    = 6'd1,
  parameter logic [5:0] MAX_FALL   = 6'd3,
  parameter logic [9:0] X_MAX      = 10'd623,
  parameter logic [9:0] DEATH_Y    = 10'd464
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  input  logic       btn_restart,
  input  logic       on_ground,
  input  logic [9:0] support_y,
  input  logic       hit_ceiling,
  input  logic       hit_left_wall,
  input  logic       hit_right_wall,
  input  logic       at_goal_region,
  input  logic       in_lava,
  output logic [9:0] player_x,
  output logic [9:0] player_y,
  output logic [1:0] motion_state,
  output logic       facing_left,
  output logic       player_dead,
  output logic       level_complete
);

  typedef enum logic [1:0] {
    StGround = 2'b00,
    StAir    = 2'b01,
    StDead   = 2'b10,
    StWon    = 2'b11
  } state_e;

  state_e            state;
  logic signed [5:0] vel_y;         // negative = moving up
  logic              jump_prev;
  logic              jump_pending;  // buffers a jump press until the next frame

  logic        go_right, go_left;
  logic [9:0]  x_walk, land_y, jump_y, air_y;
  logic [11:0] y_sum;
  logic        air_sat;
  logic [6:0]  vel_inc;
  logic [5:0]  vel_fall;

  assign motion_state = state;

  always_comb begin
    go_right = btn_right & ~btn_left;
    go_left  = btn_left & ~btn_right;

    x_walk = player_x;
    if (go_right && !hit_right_wall) begin
      x_walk = (player_x >= X_MAX - WALK_SPEED) ? X_MAX : player_x + WALK_SPEED;
    end else if (go_left && !hit_left_wall) begin
      x_walk = (player_x < WALK_SPEED) ? 10'd0 : player_x - WALK_SPEED;
    end

    land_y = support_y - 10'd16;
    jump_y = (player_y < {4'd0, JUMP_V}) ? 10'd0 : player_y - {4'd0, JUMP_V};

    // Signed 12-bit sum so an upward move past the top of screen shows up as negative.
    y_sum   = {2'b00, player_y} + {{6{vel_y[5]}}, vel_y};
    air_sat = y_sum[11];
    air_y   = air_sat ? 10'd0 : y_sum[9:0];

    vel_inc  = {vel_y[5], vel_y} + {1'b0, GRAVITY};
    vel_fall = ($signed(vel_inc) > $signed({1'b0, MAX_FALL})) ? MAX_FALL : vel_inc[5:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      player_x       <= SPAWN_X;
      player_y       <= SPAWN_Y;
      vel_y          <= '0;
      state          <= StAir;
      facing_left    <= 1'b0;
      jump_prev      <= 1'b0;
      jump_pending   <= 1'b0;
      player_dead    <= 1'b0;
      level_complete <= 1'b0;
    end else begin
      jump_prev <= btn_jump;
      // A frame consumes (or discards) any buffered press.
      if (frame_tick) begin
        jump_pending <= 1'b0;
      end else if (btn_jump && !jump_prev) begin
        jump_pending <= 1'b1;
      end

      if (frame_tick) begin
        if (state == StGround || state == StAir) begin
          player_x <= x_walk;
          if (go_right) begin
            facing_left <= 1'b0;
          end else if (go_left) begin
            facing_left <= 1'b1;
          end
        end

        unique case (state)
          StGround: begin
            if (in_lava) begin
              state       <= StDead;
              player_dead <= 1'b1;
            end else if (at_goal_region) begin
              state          <= StWon;
              level_complete <= 1'b1;
            end else if (jump_pending) begin
              vel_y    <= 6'd0 - JUMP_V;
              player_y <= jump_y;
              state    <= StAir;
            end else if (!on_ground) begin
              vel_y <= GRAVITY;
              state <= StAir;
            end else begin
              player_y <= land_y;
              vel_y    <= '0;
            end
          end
          StAir: begin
            if (in_lava) begin
              state       <= StDead;
              player_dead <= 1'b1;
            end else if (!vel_y[5] && on_ground) begin
              player_y <= land_y;
              vel_y    <= '0;
              state    <= StGround;
            end else if (vel_y[5] && hit_ceiling) begin
              vel_y <= '0;
            end else begin
              player_y <= air_y;
              vel_y    <= air_sat ? 6'd0 : vel_fall;
              if (air_y > DEATH_Y) begin
                state       <= StDead;
                player_dead <= 1'b1;
              end
            end
          end
          StDead, StWon: begin
            if (btn_restart) begin
              player_x       <= SPAWN_X;
              player_y       <= SPAWN_Y;
              vel_y          <= '0;
              state          <= StAir;
              facing_left    <= 1'b0;
              player_dead    <= 1'b0;
              level_complete <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_player_motion.sv
module tb_player_motion;

  logic       clk = 1'b0;
  logic       reset = 1'b1, frame_tick = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0, btn_restart = 1'b0;
  logic       on_ground = 1'b0, hit_ceiling = 1'b0, hit_left_wall = 1'b0, hit_right_wall = 1'b0;
  logic       at_goal_region = 1'b0, in_lava = 1'b0;
  logic [9:0] support_y = 10'd360;
  logic [9:0] player_x, player_y;
  logic [1:0] motion_state;
  logic       facing_left, player_dead, level_complete;

  player_motion dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump), .btn_restart(btn_restart),
    .on_ground(on_ground), .support_y(support_y), .hit_ceiling(hit_ceiling),
    .hit_left_wall(hit_left_wall), .hit_right_wall(hit_right_wall),
    .at_goal_region(at_goal_region), .in_lava(in_lava),
    .player_x(player_x), .player_y(player_y), .motion_state(motion_state),
    .facing_left(facing_left), .player_dead(player_dead), .level_complete(level_complete)
  );

  always #5 clk = ~clk;

  localparam int GROUND = 0, AIR = 1, DEAD = 2, WON = 3;

  // Reference model: plain integers, rules applied directly.
  int m_x, m_y, m_vel, m_st;
  bit m_face, m_pend, m_prev;
  int checks = 0, failures = 0;
  int env_mode = 0;  // -1: caller drives flags; 0 flat floor; 1 floor + block at 240; 2 floor with gap

  function automatic void model_spawn();
    m_x = 10; m_y = 344; m_vel = 0; m_st = AIR; m_face = 0;
  endfunction

  function automatic void model_tick();
    bit r, l;
    if (m_st == DEAD || m_st == WON) begin
      if (btn_restart) model_spawn();
      return;
    end
    r = btn_right && !btn_left;
    l = btn_left && !btn_right;
    if (r && !hit_right_wall) m_x = (m_x + 2 > 623) ? 623 : m_x + 2;
    else if (l && !hit_left_wall) m_x = (m_x - 2 < 0) ? 0 : m_x - 2;
    if (r) m_face = 0;
    else if (l) m_face = 1;
    if (m_st == GROUND) begin
      if (in_lava) m_st = DEAD;
      else if (at_goal_region) m_st = WON;
      else if (m_pend) begin
        m_vel = -8; m_y = (m_y < 8) ? 0 : m_y - 8; m_st = AIR;
      end else if (!on_ground) begin
        m_vel = 1; m_st = AIR;
      end else begin
        m_y = int'(support_y) - 16; m_vel = 0;
      end
    end else begin
      if (in_lava) m_st = DEAD;
      else if (m_vel >= 0 && on_ground) begin
        m_y = int'(support_y) - 16; m_vel = 0; m_st = GROUND;
      end else if (m_vel < 0 && hit_ceiling) m_vel = 0;
      else begin
        if (m_y + m_vel < 0) begin
          m_y = 0; m_vel = 0;
        end else begin
          m_y = m_y + m_vel;
          m_vel = (m_vel + 1 > 3) ? 3 : m_vel + 1;
        end
        if (m_y > 464) m_st = DEAD;
      end
    end
  endfunction

  function automatic void model_clock();
    if (reset) begin
      model_spawn(); m_pend = 0; m_prev = 0;
    end else begin
      if (frame_tick) model_tick();
      if (frame_tick) m_pend = 0;
      else if (btn_jump && !m_prev) m_pend = 1;
      m_prev = btn_jump;
    end
  endfunction

  function automatic logic [23:0] model_vec();
    logic [9:0] x, y;
    logic [1:0] s;
    x = m_x[9:0]; y = m_y[9:0]; s = m_st[1:0];
    return {x, y, s, m_face, m_st == DEAD, m_st == WON};
  endfunction

  function automatic logic [23:0] dut_vec();
    return {player_x, player_y, motion_state, facing_left, player_dead, level_complete};
  endfunction

  // Toy level seen by the collision checker, derived from the model's position.
  function automatic void drive_env();
    bit over;
    if (env_mode < 0) return;
    over = (env_mode != 2) || (m_x <= 59) || (m_x + 15 >= 90);
    support_y = 10'd360;
    on_ground = over && (m_y + 16 >= 360) && (m_y + 16 < 363);
    hit_right_wall = (env_mode == 1) && (m_x + 16 >= 240) && (m_x < 256);
    hit_left_wall = 1'b0;
  endfunction

  task automatic do_cycle(input bit tk);
    @(negedge clk);
    drive_env();
    frame_tick = tk;
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic test_reset();
    logic [23:0] want;
    env_mode = 0;
    reset = 1'b1; btn_jump = 1'b1; btn_right = 1'b1;
    do_cycle(1'b1);
    do_cycle(1'b1);  // reset with coincident tick
    want = {10'd10, 10'd344, 2'b01, 3'b000};
    checks++;
    if (dut_vec() !== want) begin
      failures++; $display("FAIL reset_state got=%h want=%h", dut_vec(), want);
    end
    reset = 1'b0; btn_jump = 1'b0; btn_right = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b0);
      do_cycle(1'b1);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL settle_tick%0d got=%h want=%h", i, dut_vec(), model_vec());
      end
    end
    want = {10'd10, 10'd344, 2'b00, 3'b000};
    checks++;
    if (dut_vec() !== want) begin
      failures++; $display("FAIL settle_ground got=%h want=%h", dut_vec(), want);
    end
  endtask

  task automatic test_walk();
    int x0;
    x0 = m_x;
    btn_right = 1'b1;
    for (int i = 0; i < 10; i++) begin
      do_cycle(1'b1);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL walk_tick%0d got=%h want=%h", i, dut_vec(), model_vec());
      end
    end
    btn_right = 1'b0;
    checks++;
    if (player_x !== 10'(x0 + 20) || player_y !== 10'd344 || facing_left !== 1'b0) begin
      failures++;
      $display("FAIL walk_total got x=%0d y=%0d fl=%b want x=%0d y=344 fl=0",
               player_x, player_y, facing_left, x0 + 20);
    end
  endtask

  task automatic test_jump();
    bit landed;
    btn_jump = 1'b1; do_cycle(1'b0);
    btn_jump = 1'b0; do_cycle(1'b0);
    do_cycle(1'b1);
    checks++;
    if (player_y !== 10'd336 || motion_state !== 2'b01) begin
      failures++; $display("FAIL jump_launch got y=%0d st=%b want y=336 st=01", player_y, motion_state);
    end
    landed = 0;
    for (int i = 0; i < 40 && !landed; i++) begin
      do_cycle(1'b1);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL jump_tick%0d got=%h want=%h", i, dut_vec(), model_vec());
      end
      landed = (m_st == GROUND);
    end
    checks++;
    if (!landed || player_y !== 10'd344 || motion_state !== 2'b00) begin
      failures++; $display("FAIL jump_land got y=%0d st=%b want y=344 st=00", player_y, motion_state);
    end
  endtask

  task automatic test_wall();
    env_mode = 1;
    btn_right = 1'b1;
    for (int i = 0; i < 120; i++) begin
      do_cycle(1'b1);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL wall_tick%0d got=%h want=%h", i, dut_vec(), model_vec());
      end
    end
    btn_right = 1'b0;
    checks++;
    if (player_x !== 10'd224 || motion_state !== 2'b00) begin
      failures++; $display("FAIL wall_stop got x=%0d st=%b want x=224 st=00", player_x, motion_state);
    end
  endtask

  task automatic test_gap_death();
    bit died;
    env_mode = 2;
    reset = 1'b1; do_cycle(1'b0); reset = 1'b0;
    do_cycle(1'b1); do_cycle(1'b1);
    btn_right = 1'b1;
    died = 0;
    for (int i = 0; i < 150 && !died; i++) begin
      do_cycle(1'b1);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL gap_tick%0d got=%h want=%h", i, dut_vec(), model_vec());
      end
      died = (m_st == DEAD);
    end
    checks++;
    if (!died || player_dead !== 1'b1 || motion_state !== 2'b10 || player_y <= 10'd464) begin
      failures++;
      $display("FAIL gap_dead got dead=%b st=%b y=%0d want dead=1 st=10 y>464",
               player_dead, motion_state, player_y);
    end
    for (int i = 0; i < 3; i++) begin  // frozen while dead
      do_cycle(1'b1);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL dead_frozen%0d got=%h want=%h", i, dut_vec(), model_vec());
      end
    end
    btn_right = 1'b0;
  endtask

  task automatic test_goal_restart();
    logic [23:0] want;
    env_mode = 0;
    reset = 1'b1; do_cycle(1'b0); reset = 1'b0;
    do_cycle(1'b1); do_cycle(1'b1);
    at_goal_region = 1'b1; btn_jump = 1'b1; do_cycle(1'b0); btn_jump = 1'b0;
    do_cycle(1'b1);  // goal beats the buffered jump
    at_goal_region = 1'b0;
    checks++;
    if (motion_state !== 2'b11 || level_complete !== 1'b1 || player_y !== 10'd344) begin
      failures++;
      $display("FAIL goal_won got st=%b lc=%b y=%0d want st=11 lc=1 y=344",
               motion_state, level_complete, player_y);
    end
    btn_left = 1'b1; do_cycle(1'b1); btn_left = 1'b0;
    checks++;
    if (dut_vec() !== model_vec()) begin
      failures++; $display("FAIL won_frozen got=%h want=%h", dut_vec(), model_vec());
    end
    btn_restart = 1'b1; do_cycle(1'b1); btn_restart = 1'b0;
    want = {10'd10, 10'd344, 2'b01, 3'b000};
    checks++;
    if (dut_vec() !== want) begin
      failures++; $display("FAIL restart got=%h want=%h", dut_vec(), want);
    end
  endtask

  task automatic test_back_to_back();
    env_mode = -1;
    for (int i = 0; i < 800; i++) begin
      btn_left       = ($urandom_range(0, 2) == 0);
      btn_right      = ($urandom_range(0, 1) == 0);
      btn_jump       = ($urandom_range(0, 3) == 0);
      btn_restart    = ($urandom_range(0, 3) == 0);
      on_ground      = ($urandom_range(0, 2) == 0);
      support_y      = 10'($urandom_range(300, 420));
      hit_ceiling    = ($urandom_range(0, 3) == 0);
      hit_left_wall  = ($urandom_range(0, 4) == 0);
      hit_right_wall = ($urandom_range(0, 4) == 0);
      at_goal_region = ($urandom_range(0, 30) == 0);
      in_lava        = ($urandom_range(0, 30) == 0);
      do_cycle($urandom_range(0, 2) == 0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL random_cycle%0d got=%h want=%h", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    model_spawn(); m_pend = 0; m_prev = 0;
    test_reset();
    test_walk();
    test_jump();
    test_wall();
    test_gap_death();
    test_goal_restart();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
